// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Widths are exposed as functions so each instance can size itself from its own parameters.
package fifo_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int SLICE_BUS_W  = 1024;
  localparam int SLICE_WORD_W = 64;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m) + 1;
  endfunction

  // Default-configuration widths; instances derive their own via the functions above.
  localparam int ID_W  = id_width(4);
  localparam int CNT_W = cnt_width(4);

  // Word idx of width w from a packed bus; the caller zero-extends its bus to SLICE_BUS_W.
  function automatic logic [SLICE_WORD_W-1:0] slice_word(
    input logic [SLICE_BUS_W-1:0] bus,
    input int unsigned            idx,
    input int unsigned            w
  );
    logic [SLICE_BUS_W-1:0]  sh;
    logic [SLICE_WORD_W-1:0] mask;
    sh   = bus >> (idx * w);
    mask = (w >= 32'(SLICE_WORD_W)) ? '1 : ((SLICE_WORD_W'(1) << w) - SLICE_WORD_W'(1));
    return sh[SLICE_WORD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/rr_next_picker.sv
// Round-robin search: first requester after last_i, wrapping, with last_i itself checked last.
module rr_next_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    next_o
);

  // Walk from the farthest candidate back to the nearest so the nearest hit is written last.
  always_comb begin
    int idx;
    idx     = 0;
    valid_o = 1'b0;
    next_o  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        valid_o = 1'b1;
        next_o  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: NUM_REQ producers share one FIFO write port in bounded bursts.
// Outputs are combinational off the owner register; full stalls without ending the burst.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int Num_of_bits = 8,
  parameter  int MAX_BURST   = 4,
  localparam int IDW         = id_width(NUM_REQ),
  localparam int CNTW        = cnt_width(MAX_BURST)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*Num_of_bits-1:0] req_data,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           fifo_full,
  output logic                           write_enable,
  output logic [Num_of_bits-1:0]         fifo_in,
  output logic [IDW-1:0]                 grant_id,
  output logic                           busy
);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_q,  last_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;

  // Picker 0 arbitrates from IDLE; picker 1 computes the handoff with the owner as last.
  logic [1:0][IDW-1:0] pick_last;
  logic [1:0]          pick_vld;
  logic [1:0][IDW-1:0] pick_idx;

  assign pick_last[0] = last_q;
  assign pick_last[1] = owner_q;

  for (genvar p = 0; p < 2; p++) begin : g_pick
    rr_next_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (IDW)
    ) u_pick (
      .req_i   (req),
      .last_i  (pick_last[p]),
      .valid_o (pick_vld[p]),
      .next_o  (pick_idx[p])
    );
  end

  logic                   in_burst;
  logic                   owner_req;
  logic                   wr_core;
  logic                   last_beat;
  logic                   term;
  logic [SLICE_BUS_W-1:0] bus_ext;
  logic [Num_of_bits-1:0] owner_word;

  assign in_burst   = (state_q == BURST);
  assign owner_req  = req[owner_q];
  assign wr_core    = in_burst & owner_req & ~fifo_full;
  assign last_beat  = (cnt_q == CNTW'(MAX_BURST - 1));
  assign term       = in_burst & (~owner_req | (wr_core & last_beat));
  assign bus_ext    = SLICE_BUS_W'(req_data);
  assign owner_word = Num_of_bits'(slice_word(bus_ext, 32'(owner_q), Num_of_bits));

  // Reset masks the strobes combinationally so an aborted burst never writes.
  always_comb begin
    write_enable = wr_core & ~reset;
    busy         = in_burst & ~reset;
    ack          = write_enable ? (NUM_REQ'(1) << owner_q) : '0;
    grant_id     = owner_q;
    fifo_in      = busy ? owner_word : '0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld[0]) begin
          owner_d = pick_idx[0];
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (wr_core) cnt_d = cnt_q + CNTW'(1);
        if (term) begin
          last_d = owner_q;
          cnt_d  = '0;
          if (pick_vld[1]) owner_d = pick_idx[1];
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
